// File: rtl/rv_width_converter.sv
// Byte <-> word ready-valid width converter for the host link / register interface boundary.
// Receive assembles WORD_BYTES little-endian bytes into a word; transmit serializes a word into bytes.
module rv_width_converter #(
  parameter int BYTE_WIDTH = 8,
  parameter int WORD_BYTES = 4
) (
  input  logic                             CLK_I,
  input  logic                             RST_I,
  input  logic                             RX_VALID_I,
  output logic                             RX_READY_O,
  input  logic [BYTE_WIDTH-1:0]            RX_DATA_I,
  output logic                             WORD_VALID_O,
  input  logic                             WORD_READY_I,
  output logic [BYTE_WIDTH*WORD_BYTES-1:0] WORD_DATA_O,
  input  logic                             WORD_VALID_I,
  output logic                             WORD_READY_O,
  input  logic [BYTE_WIDTH*WORD_BYTES-1:0] WORD_DATA_I,
  output logic                             TX_VALID_O,
  input  logic                             TX_READY_I,
  output logic [BYTE_WIDTH-1:0]            TX_DATA_O,
  input  logic                             FLUSH_I
);

  localparam int W     = BYTE_WIDTH * WORD_BYTES;
  localparam int CNT_W = $clog2(WORD_BYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_BYTES - 1);

  typedef enum logic { COLLECT, HOLD } rx_state_t;
  typedef enum logic { IDLE, SEND } tx_state_t;

  rx_state_t        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
  logic [W-1:0]     rx_word, rx_word_nxt;
  logic             rx_ready;

  tx_state_t        tx_state, tx_state_nxt;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
  logic [W-1:0]     tx_sh, tx_sh_nxt;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_state <= COLLECT;
      rx_cnt   <= '0;
      rx_word  <= '0;
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_sh    <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_word  <= rx_word_nxt;
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_sh    <= tx_sh_nxt;
    end
  end

  // Receive: a flush only clears the byte count; bytes already written are overwritten later.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_word_nxt  = rx_word;
    rx_ready     = 1'b0;
    WORD_VALID_O = 1'b0;
    case (rx_state)
      COLLECT: begin
        rx_ready = !FLUSH_I;
        if (FLUSH_I) begin
          rx_cnt_nxt = '0;
        end else if (RX_VALID_I) begin
          for (int i = 0; i < WORD_BYTES; i++) begin
            if (rx_cnt == CNT_W'(i)) rx_word_nxt[i*BYTE_WIDTH +: BYTE_WIDTH] = RX_DATA_I;
          end
          if (rx_cnt == LAST) begin
            rx_cnt_nxt   = '0;
            rx_state_nxt = HOLD;
          end else begin
            rx_cnt_nxt = rx_cnt + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        WORD_VALID_O = 1'b1;
        if (WORD_READY_I) rx_state_nxt = COLLECT;
      end
      default: rx_state_nxt = COLLECT;
    endcase
  end

  // Transmit: the shift register zero-fills so TX_DATA_O idles at zero after a word drains.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_sh_nxt    = tx_sh;
    TX_VALID_O   = 1'b0;
    case (tx_state)
      IDLE: begin
        if (WORD_VALID_I) begin
          tx_sh_nxt    = WORD_DATA_I;
          tx_cnt_nxt   = '0;
          tx_state_nxt = SEND;
        end
      end
      SEND: begin
        TX_VALID_O = 1'b1;
        if (TX_READY_I) begin
          tx_sh_nxt = tx_sh >> BYTE_WIDTH;
          if (tx_cnt == LAST) tx_state_nxt = IDLE;
          else                tx_cnt_nxt   = tx_cnt + CNT_W'(1);
        end
      end
      default: tx_state_nxt = IDLE;
    endcase
  end

  // Ready outputs are combinational from state, so reset must gate them explicitly.
  assign RX_READY_O   = rx_ready && !RST_I;
  assign WORD_READY_O = (tx_state == IDLE) && !RST_I;
  assign WORD_DATA_O  = rx_word;
  assign TX_DATA_O    = tx_sh[BYTE_WIDTH-1:0];

endmodule

// File: tb/tb_rv_width_converter.sv
// Directed self-checking bench for rv_width_converter (BYTE_WIDTH=8, WORD_BYTES=4).
module tb_rv_width_converter;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        RX_VALID_I;
  logic        RX_READY_O;
  logic [7:0]  RX_DATA_I;
  logic        WORD_VALID_O;
  logic        WORD_READY_I;
  logic [31:0] WORD_DATA_O;
  logic        WORD_VALID_I;
  logic        WORD_READY_O;
  logic [31:0] WORD_DATA_I;
  logic        TX_VALID_O;
  logic        TX_READY_I;
  logic [7:0]  TX_DATA_O;
  logic        FLUSH_I;

  int vectors = 0;
  int miscompares = 0;

  rv_width_converter #(.BYTE_WIDTH(8), .WORD_BYTES(4)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .RX_VALID_I(RX_VALID_I), .RX_READY_O(RX_READY_O), .RX_DATA_I(RX_DATA_I),
    .WORD_VALID_O(WORD_VALID_O), .WORD_READY_I(WORD_READY_I), .WORD_DATA_O(WORD_DATA_O),
    .WORD_VALID_I(WORD_VALID_I), .WORD_READY_O(WORD_READY_O), .WORD_DATA_I(WORD_DATA_I),
    .TX_VALID_O(TX_VALID_O), .TX_READY_I(TX_READY_I), .TX_DATA_O(TX_DATA_O),
    .FLUSH_I(FLUSH_I)
  );

  always #5 CLK_I = ~CLK_I;

  // Advance to just after the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic test_reset();
    RST_I = 1'b1; RX_VALID_I = 1'b1; RX_DATA_I = 8'h5A; WORD_READY_I = 1'b1;
    WORD_VALID_I = 1'b1; WORD_DATA_I = 32'hCAFEF00D; TX_READY_I = 1'b1; FLUSH_I = 1'b0;
    #2;
    vectors++; if (RX_READY_O !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rx_ready: got %b expected 0", RX_READY_O); end
    vectors++; if (WORD_READY_O !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_word_ready: got %b expected 0", WORD_READY_O); end
    vectors++; if (WORD_VALID_O !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_word_valid: got %b expected 0", WORD_VALID_O); end
    vectors++; if (TX_VALID_O !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", TX_VALID_O); end
    vectors++; if (WORD_DATA_O !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_word_data: got %h expected 00000000", WORD_DATA_O); end
    vectors++; if (TX_DATA_O !== 8'h0) begin miscompares++; $display("[TB] FAIL reset_tx_data: got %h expected 00", TX_DATA_O); end
    tick();
    tick();
    RST_I = 1'b0; RX_VALID_I = 1'b0; WORD_VALID_I = 1'b0; WORD_DATA_I = '0; TX_READY_I = 1'b0;
    #1;
    vectors++; if (RX_READY_O !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_rx_ready: got %b expected 1", RX_READY_O); end
    vectors++; if (WORD_READY_O !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_word_ready: got %b expected 1", WORD_READY_O); end
    tick();
  endtask

  task automatic test_rx_basic();
    logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    WORD_READY_I = 1'b1;
    for (int i = 0; i < 4; i++) begin
      RX_VALID_I = 1'b1; RX_DATA_I = b[i];
      #1;
      vectors++; if (RX_READY_O !== 1'b1 || WORD_VALID_O !== 1'b0) begin miscompares++; $display("[TB] FAIL rx_basic_collect[%0d]: got ready=%b valid=%b expected ready=1 valid=0", i, RX_READY_O, WORD_VALID_O); end
      tick();
    end
    RX_VALID_I = 1'b0;
    #1;
    vectors++; if (WORD_VALID_O !== 1'b1 || WORD_DATA_O !== 32'h44332211 || RX_READY_O !== 1'b0) begin miscompares++; $display("[TB] FAIL rx_basic_word: got valid=%b data=%h ready=%b expected valid=1 data=44332211 ready=0", WORD_VALID_O, WORD_DATA_O, RX_READY_O); end
    tick();
    vectors++; if (WORD_VALID_O !== 1'b0 || RX_READY_O !== 1'b1) begin miscompares++; $display("[TB] FAIL rx_basic_single_cycle: got valid=%b ready=%b expected valid=0 ready=1", WORD_VALID_O, RX_READY_O); end
  endtask

  task automatic test_rx_backpressure();
    logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] n [3] = '{8'h66, 8'h77, 8'h88};
    WORD_READY_I = 1'b0;
    for (int i = 0; i < 4; i++) begin
      RX_VALID_I = 1'b1; RX_DATA_I = b[i];
      tick();
    end
    RX_DATA_I = 8'h55;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++; if (WORD_VALID_O !== 1'b1 || WORD_DATA_O !== 32'h44332211 || RX_READY_O !== 1'b0) begin miscompares++; $display("[TB] FAIL rx_bp_hold[%0d]: got valid=%b data=%h ready=%b expected valid=1 data=44332211 ready=0", k, WORD_VALID_O, WORD_DATA_O, RX_READY_O); end
      tick();
    end
    WORD_READY_I = 1'b1;
    tick();
    vectors++; if (WORD_VALID_O !== 1'b0 || RX_READY_O !== 1'b1) begin miscompares++; $display("[TB] FAIL rx_bp_release: got valid=%b ready=%b expected valid=0 ready=1", WORD_VALID_O, RX_READY_O); end
    tick();
    for (int i = 0; i < 3; i++) begin
      RX_DATA_I = n[i];
      tick();
    end
    RX_VALID_I = 1'b0;
    #1;
    vectors++; if (WORD_VALID_O !== 1'b1 || WORD_DATA_O !== 32'h88776655) begin miscompares++; $display("[TB] FAIL rx_bp_next_word: got valid=%b data=%h expected valid=1 data=88776655", WORD_VALID_O, WORD_DATA_O); end
    tick();
  endtask

  task automatic test_flush();
    logic [7:0] b [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    WORD_READY_I = 1'b1;
    RX_VALID_I = 1'b1; RX_DATA_I = 8'hAA; tick();
    RX_DATA_I = 8'hBB; tick();
    RX_DATA_I = 8'hCC; FLUSH_I = 1'b1;
    #1;
    vectors++; if (RX_READY_O !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_ready: got %b expected 0", RX_READY_O); end
    tick();
    FLUSH_I = 1'b0;
    for (int i = 0; i < 4; i++) begin
      RX_DATA_I = b[i];
      #1;
      vectors++; if (WORD_VALID_O !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_early_valid[%0d]: got %b expected 0", i, WORD_VALID_O); end
      tick();
    end
    RX_VALID_I = 1'b0;
    #1;
    vectors++; if (WORD_VALID_O !== 1'b1 || WORD_DATA_O !== 32'h04030201) begin miscompares++; $display("[TB] FAIL flush_word: got valid=%b data=%h expected valid=1 data=04030201", WORD_VALID_O, WORD_DATA_O); end
    tick();
  endtask

  task automatic test_tx();
    logic [7:0] e [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    TX_READY_I = 1'b0;
    WORD_VALID_I = 1'b1; WORD_DATA_I = 32'hDEADBEEF;
    #1;
    vectors++; if (WORD_READY_O !== 1'b1 || TX_VALID_O !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_idle: got word_ready=%b tx_valid=%b expected 1/0", WORD_READY_O, TX_VALID_O); end
    tick();
    WORD_VALID_I = 1'b0; WORD_DATA_I = '0;
    for (int j = 0; j < 4; j++) begin
      TX_READY_I = 1'b0;
      #1;
      vectors++; if (TX_VALID_O !== 1'b1 || TX_DATA_O !== e[j] || WORD_READY_O !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_hold[%0d]: got valid=%b data=%h word_ready=%b expected valid=1 data=%h word_ready=0", j, TX_VALID_O, TX_DATA_O, WORD_READY_O, e[j]); end
      tick();
      TX_READY_I = 1'b1;
      #1;
      vectors++; if (TX_VALID_O !== 1'b1 || TX_DATA_O !== e[j] || WORD_READY_O !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_send[%0d]: got valid=%b data=%h word_ready=%b expected valid=1 data=%h word_ready=0", j, TX_VALID_O, TX_DATA_O, WORD_READY_O, e[j]); end
      tick();
    end
    TX_READY_I = 1'b0;
    #1;
    vectors++; if (TX_VALID_O !== 1'b0 || WORD_READY_O !== 1'b1) begin miscompares++; $display("[TB] FAIL tx_done: got valid=%b word_ready=%b expected 0/1", TX_VALID_O, WORD_READY_O); end
  endtask

  task automatic test_concurrent_reset();
    logic [7:0] fresh [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0] tx_exp [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    WORD_READY_I = 1'b1; TX_READY_I = 1'b1;
    RX_VALID_I = 1'b1; RX_DATA_I = 8'h11;
    WORD_VALID_I = 1'b1; WORD_DATA_I = 32'hDEADBEEF;
    tick();
    WORD_VALID_I = 1'b0; WORD_DATA_I = '0; RX_DATA_I = 8'h22;
    #1;
    vectors++; if (TX_VALID_O !== 1'b1 || TX_DATA_O !== 8'hEF) begin miscompares++; $display("[TB] FAIL conc_tx0: got valid=%b data=%h expected 1/ef", TX_VALID_O, TX_DATA_O); end
    tick();
    RX_VALID_I = 1'b0;
    #1;
    vectors++; if (TX_DATA_O !== 8'hBE) begin miscompares++; $display("[TB] FAIL conc_tx1: got %h expected be", TX_DATA_O); end
    tick();
    RST_I = 1'b1; RX_VALID_I = 1'b1; RX_DATA_I = 8'h99;
    #1;
    vectors++; if ({RX_READY_O, WORD_VALID_O, WORD_READY_O, TX_VALID_O} !== 4'b0 || WORD_DATA_O !== 32'h0 || TX_DATA_O !== 8'h0) begin miscompares++; $display("[TB] FAIL conc_reset_outputs: got rr=%b wv=%b wr=%b tv=%b wd=%h td=%h expected all 0", RX_READY_O, WORD_VALID_O, WORD_READY_O, TX_VALID_O, WORD_DATA_O, TX_DATA_O); end
    tick();
    RST_I = 1'b0;
    for (int i = 0; i < 4; i++) begin
      RX_DATA_I = fresh[i];
      #1;
      vectors++; if (TX_VALID_O !== 1'b0 || RX_READY_O !== 1'b1) begin miscompares++; $display("[TB] FAIL conc_post_reset[%0d]: got tx_valid=%b rx_ready=%b expected 0/1", i, TX_VALID_O, RX_READY_O); end
      tick();
    end
    RX_VALID_I = 1'b0;
    #1;
    vectors++; if (WORD_VALID_O !== 1'b1 || WORD_DATA_O !== 32'hD4C3B2A1) begin miscompares++; $display("[TB] FAIL conc_fresh_word: got valid=%b data=%h expected 1/d4c3b2a1", WORD_VALID_O, WORD_DATA_O); end
    WORD_VALID_I = 1'b1; WORD_DATA_I = 32'h12345678;
    tick();
    WORD_VALID_I = 1'b0; WORD_DATA_I = '0;
    for (int j = 0; j < 4; j++) begin
      #1;
      vectors++; if (TX_VALID_O !== 1'b1 || TX_DATA_O !== tx_exp[j]) begin miscompares++; $display("[TB] FAIL conc_fresh_tx[%0d]: got valid=%b data=%h expected 1/%h", j, TX_VALID_O, TX_DATA_O, tx_exp[j]); end
      tick();
    end
    #1;
    vectors++; if (TX_VALID_O !== 1'b0 || WORD_READY_O !== 1'b1) begin miscompares++; $display("[TB] FAIL conc_fresh_tx_done: got valid=%b word_ready=%b expected 0/1", TX_VALID_O, WORD_READY_O); end
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_rx_backpressure();
    test_flush();
    test_tx();
    test_concurrent_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv_width_converter.md
# rv_width_converter

Bidirectional width converter between the byte-wide ready-valid stream of the serial host link and the word-wide ready-valid bus of the register interface stage. On the receive path it assembles WORD_BYTES consecutive bytes into one word and presents it downstream. On the transmit path it accepts one word and serializes it into WORD_BYTES bytes. Both paths are independent, share one clock and reset, and use little-endian byte order: the first byte on the byte stream is bits [7:0] of the word.

## Interface
Parameters:
- BYTE_WIDTH, 8, width of the byte stream.
- WORD_BYTES, 4, bytes per word; must be ≥ 2. Word width W = BYTE_WIDTH*WORD_BYTES.

Ports:
- CLK_I  in  1  single clock; all logic on rising edge.
- RST_I  in  1  asynchronous, active-high reset.
- RX_VALID_I  in  1  upstream byte valid.
- RX_READY_O  out  1  converter accepts a byte.
- RX_DATA_I  in  BYTE_WIDTH  upstream byte.
- WORD_VALID_O  out  1  assembled word available.
- WORD_READY_I  in  1  downstream (register interface write side) accepts word.
- WORD_DATA_O  out  W  assembled word.
- WORD_VALID_I  in  1  word to transmit valid (from register interface read side).
- WORD_READY_O  out  1  converter accepts a word.
- WORD_DATA_I  in  W  word to transmit.
- TX_VALID_O  out  1  outgoing byte valid.
- TX_READY_I  in  1  host link accepts byte.
- TX_DATA_O  out  BYTE_WIDTH  outgoing byte.
- FLUSH_I  in  1  synchronous discard of a partially assembled receive word.

## Operation
- Handshake: transfer occurs on the rising edge where VALID and READY are both 1. Once asserted, a VALID output stays 1 with stable data until transferred.
- Receive FSM, states COLLECT and HOLD; byte counter rx_cnt, width ceil(log2(WORD_BYTES)); word register rx_word.
  - COLLECT: RX_READY_O = 1 unless FLUSH_I = 1. On accept: rx_word[rx_cnt*BYTE_WIDTH +: BYTE_WIDTH] ← RX_DATA_I. If rx_cnt = WORD_BYTES-1, rx_cnt ← 0 and go to HOLD. Otherwise rx_cnt ← rx_cnt+1.
  - HOLD: WORD_VALID_O = 1, RX_READY_O = 0. On word transfer, go to COLLECT.
  - WORD_DATA_O = rx_word at all times. It is only meaningful while WORD_VALID_O = 1.
  - FLUSH_I in COLLECT: rx_cnt ← 0 and no byte is accepted that cycle. FLUSH_I in HOLD is ignored; the completed word is kept.
- Transmit FSM, states IDLE and SEND; counter tx_cnt; shift register tx_sh.
  - IDLE: WORD_READY_O = 1, TX_VALID_O = 0. On accept: tx_sh ← WORD_DATA_I, tx_cnt ← 0, go to SEND.
  - SEND: WORD_READY_O = 0, TX_VALID_O = 1, TX_DATA_O = tx_sh[BYTE_WIDTH-1:0]. On byte transfer: tx_sh ← tx_sh >> BYTE_WIDTH (zero fill). If tx_cnt = WORD_BYTES-1, go to IDLE; otherwise tx_cnt ← tx_cnt+1.
- FLUSH_I has no effect on the transmit path.

## Timing
- Reset: while RST_I = 1, every output is 0 (RX_READY_O and WORD_READY_O are gated by reset). State returns to COLLECT/IDLE, and all counters and registers are cleared.
- Reset asserted mid-word on either path discards that word. Nothing partial is ever emitted.
- First clock edge after reset release: RX_READY_O = 1 and WORD_READY_O = 1.
- Receive latency: WORD_VALID_O rises the cycle after the last byte is accepted. The earliest next byte is accepted the cycle after the word transfer. Peak rate is one word per WORD_BYTES+1 cycles.
- Transmit latency: TX_VALID_O rises the cycle after word acceptance, and the first byte can transfer in that cycle. WORD_READY_O returns 1 the cycle after the last byte transfer. Peak rate is one word per WORD_BYTES+1 cycles.
- A byte with RX_VALID_I = 1 while RX_READY_O = 0 is not consumed; the upstream source holds it.
- The receive and transmit paths may each complete a transfer in the same cycle with no interaction.
- Counters wrap only through the explicit reset to 0 at WORD_BYTES-1. No other wrap-around exists.

## Test plan
- Receive basic, WORD_BYTES = 4: bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles with WORD_READY_I = 1 -> WORD_VALID_O for exactly 1 cycle, WORD_DATA_O = 0x44332211, and RX_READY_O = 0 during that cycle.
- Receive backpressure: same bytes with WORD_READY_I = 0 for 5 cycles -> WORD_VALID_O and 0x44332211 held stable for 5 cycles. Byte 0x55 offered meanwhile is not accepted. After the transfer, 0x55 lands in bits [7:0] of the next word.
- Flush: bytes 0xAA, 0xBB, then FLUSH_I for one cycle while 0xCC is valid -> 0xCC not accepted. The following bytes 0x01, 0x02, 0x03, 0x04 yield 0x04030201.
- Transmit: WORD_DATA_I = 0xDEADBEEF with TX_READY_I toggling 1/0 -> TX_DATA_O sequence 0xEF, 0xBE, 0xAD, 0xDE with each byte held while not ready. WORD_READY_O = 0 until the cycle after 0xDE transfers.
- Concurrent paths plus reset: the receive and transmit tests run simultaneously, then RST_I is pulsed after byte 2 of each -> all outputs 0 immediately. The next receive word assembles from a fresh byte 0, and no stale transmit byte appears.
